sisc_fetch_unit: RTL

- Parametrised, buffered instruction-fetch front end for the SISC core.
- Replaces the single-register PC and instruction-register path with four parts:
  - a free-running fetch PC;
  - an instruction-memory request interface that allows multiple requests in flight;
  - a DEPTH-entry prefetch FIFO of {pc, instr} pairs;
  - branch redirect with flush of all buffered and in-flight fetches.
- Sits between instruction memory and the control/decode stage. The consumer pulls instructions with a valid/ready handshake.

---
 rtl/sisc_fetch_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: buffered instruction-fetch front end for the SISC core.
// A free-running fetch PC issues one word-addressed request per cycle while
// credit is available. In-order responses fill a DEPTH-entry {pc, instr}
// FIFO that the decode stage drains with a valid/ready handshake. A branch
// redirect flushes the FIFO, and responses still in flight are discarded.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst_f        synchronous reset, active-high
//   fetch_en     allows new memory requests
//   imem_req     request strobe (combinational), one word per cycle
//   imem_addr    request address, which is the current fetch PC (combinational)
//   imem_rdata   returned instruction word
//   imem_rvalid  imem_rdata valid; responses return in request order
//   br_taken     redirect pulse
//   br_target    redirect address
//   ir_valid     FIFO head valid
//   ir_instr     FIFO head instruction
//   ir_pc        address of the FIFO head instruction
//   ir_ready     consumer accepts the head this cycle
//   occupancy    FIFO entry count
//   err          sticky protocol error (response with nothing outstanding)
module sisc_fetch_unit #(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_f,
  input  logic                         fetch_en,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         imem_rvalid,
  input  logic                         br_taken,
  input  logic [ADDR_W-1:0]            br_target,
  output logic                         ir_valid,
  output logic [INSTR_W-1:0]           ir_instr,
  output logic [ADDR_W-1:0]            ir_pc,
  input  logic                         ir_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         err
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = OCC_W + 1;

  // Registered state
  logic [ADDR_W-1:0]  fpc_q,         fpc_d;
  logic [ADDR_W-1:0]  rpc_q,         rpc_d;
  logic [OCC_W-1:0]   outstanding_q, outstanding_d;
  logic [OCC_W-1:0]   drop_cnt_q,    drop_cnt_d;
  logic [OCC_W-1:0]   count_q,       count_d;
  logic [PTR_W-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,      rd_ptr_d;
  logic               err_q,         err_d;

  // FIFO storage; contents are only meaningful below the count
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  // Per-cycle events
  logic               has_out;
  logic [SUM_W-1:0]   credit_sum;
  logic               issue;
  logic               resp_br;
  logic               resp_ok;
  logic               spurious;
  logic               push;
  logic               pop;

  // Event decode. Buffered entries and in-flight requests share DEPTH
  // credits, so an accepted response always finds a free FIFO slot.
  always_comb begin
    has_out    = (outstanding_q != '0);
    credit_sum = SUM_W'(count_q) + SUM_W'(outstanding_q);
    issue      = ~rst_f & fetch_en & ~br_taken & (credit_sum < SUM_W'(DEPTH));
    resp_br    = imem_rvalid & has_out;
    resp_ok    = resp_br & ~br_taken;
    spurious   = imem_rvalid & ~has_out;
    push       = resp_ok & (drop_cnt_q == '0);
    pop        = (count_q != '0) & ir_ready & ~br_taken;
  end

  // Next-state logic
  always_comb begin
    fpc_d         = fpc_q;
    rpc_d         = rpc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    err_d         = err_q | spurious;

    if (br_taken) begin
      // Everything still in flight after this edge belongs to the old path.
      fpc_d         = br_target;
      rpc_d         = br_target;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = outstanding_q - OCC_W'(resp_br);
      drop_cnt_d    = outstanding_q - OCC_W'(resp_br);
    end else begin
      if (issue) begin
        fpc_d = fpc_q + ADDR_W'(1);
      end
      outstanding_d = outstanding_q + OCC_W'(issue) - OCC_W'(resp_ok);
      if (resp_ok && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - OCC_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rpc_d    = rpc_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_f) begin
      fpc_q         <= RESET_PC;
      rpc_q         <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      fpc_q         <= fpc_d;
      rpc_q         <= rpc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      err_q         <= err_d;
    end
  end

  // FIFO write port; storage needs no reset because the count gates it
  always_ff @(posedge clk) begin
    if (!rst_f && push) begin
      pc_mem[wr_ptr_q]    <= rpc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  // Outputs; status outputs are held inactive while reset is asserted
  always_comb begin
    imem_req  = issue;
    imem_addr = fpc_q;
    ir_valid  = ~rst_f & (count_q != '0);
    ir_instr  = instr_mem[rd_ptr_q];
    ir_pc     = pc_mem[rd_ptr_q];
    occupancy = rst_f ? '0 : count_q;
    err       = ~rst_f & err_q;
  end

endmodule
